// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, counts retirements, halts on faults.
module cpu_sequencer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        i_ack,
  input  logic        d_ack,
  input  logic        branch,
  output logic        i_req,
  output logic        d_req,
  output logic        d_we,
  output logic        ir_load,
  output logic        ALU_source,
  output logic        reg_write,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic [6:0]  opcode,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       taken;

  logic is_legal, is_load, is_store, is_branch, uses_imm;
  logic unused_instr_bits;

  // Only the opcode field is latched; the datapath decodes the rest itself.
  assign unused_instr_bits = ^instr[31:7];

  assign is_legal  = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign uses_imm  = opcode inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_START;
      opcode     <= '0;
      retired    <= '0;
      halt_cause <= 2'b00;
      wait_cnt   <= '0;
      taken      <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          // An ack on the last permitted cycle still wins over the timeout.
          if (i_ack) begin
            opcode <= instr[6:0];
            state  <= S_DECODE;
          end else if (wait_cnt == WAIT_LIM) begin
            halt_cause <= 2'b10;
            state      <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            halt_cause <= 2'b01;
            state      <= S_HALT;
          end
        end
        S_EXEC: begin
          taken    <= branch && is_branch;
          wait_cnt <= '0;
          state    <= (is_load || is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (d_ack) begin
            state <= S_WB;
          end else if (wait_cnt == WAIT_LIM) begin
            halt_cause <= 2'b10;
            state      <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          retired  <= retired + 32'd1;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_START;
      endcase
    end
  end

  // Moore decode of the strobes; ir_load alone also looks at i_ack.
  always_comb begin
    i_req      = 1'b0;
    ir_load    = 1'b0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    ALU_source = 1'b0;
    reg_write  = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = 2'b00;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        i_req   = 1'b1;
        ir_load = i_ack;
      end
      S_EXEC: ALU_source = uses_imm;
      S_MEM: begin
        d_req      = 1'b1;
        d_we       = is_store;
        ALU_source = 1'b1;
      end
      S_WB: begin
        pc_load   = 1'b1;
        reg_write = !(is_store || is_branch);
        if (taken)                  pc_sel = 2'b01;
        else if (opcode == OP_JAL)  pc_sel = 2'b10;
        else if (opcode == OP_JALR) pc_sel = 2'b11;
        else                        pc_sel = 2'b00;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: builds a per-cycle expected trace from instruction-level
// descriptions (ack delays, branch outcome), then replays stimulus and compares.
module tb_cpu_sequencer;

  localparam int unsigned WAIT_MAX = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        i_ack = 1'b0, d_ack = 1'b0, branch = 1'b0;
  logic        i_req, d_req, d_we, ir_load, ALU_source, reg_write, pc_load, halted;
  logic [1:0]  pc_sel, halt_cause;
  logic [6:0]  opcode;
  logic [31:0] retired;

  cpu_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .instr(instr), .i_ack(i_ack), .d_ack(d_ack), .branch(branch),
    .i_req(i_req), .d_req(d_req), .d_we(d_we), .ir_load(ir_load), .ALU_source(ALU_source),
    .reg_write(reg_write), .pc_load(pc_load), .pc_sel(pc_sel), .opcode(opcode),
    .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        r, ia, da, br;
    logic [31:0] ins;
    logic [9:0]  ctl;
    logic        alu, alu_care;
    logic [6:0]  opc;
    logic [31:0] ret;
  } cyc_t;

  cyc_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, cyc_no = 0;
  logic [6:0]  m_opcode = '0;
  logic [31:0] m_retired = '0;
  logic [1:0]  m_cause = 2'b00;
  logic [6:0]  legal_ops [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc_no, got, exp);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [9:0] ctl_v(input logic e_i_req, e_ir_load, e_d_req, e_d_we,
                                       e_reg_write, e_pc_load, input logic [1:0] e_pc_sel,
                                       input logic e_halted, input logic [1:0] e_cause);
    return {e_i_req, e_ir_load, e_d_req, e_d_we, e_reg_write, e_pc_load, e_pc_sel,
            e_halted, e_cause};
  endfunction

  function automatic logic [9:0] ctl_now();
    return {i_req, ir_load, d_req, d_we, reg_write, pc_load, pc_sel, halted, halt_cause};
  endfunction

  task automatic push(input logic r, ia, da, br, input logic [31:0] ins,
                      input logic [9:0] ctl, input logic alu, care);
    cyc_t c;
    c.r = r; c.ia = ia; c.da = da; c.br = br; c.ins = ins; c.ctl = ctl;
    c.alu = alu; c.alu_care = care; c.opc = m_opcode; c.ret = m_retired;
    exp_q.push_back(c);
  endtask

  // driver tasks: each one appends the cycles an instruction-level event should produce
  task automatic start_cycle();
    push(0, rb(), rb(), rb(), $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
  endtask

  // n halted cycles, the last one carrying rst; the model then returns to reset state
  task automatic halt_reset(input int n);
    for (int i = 0; i < n; i++)
      push((i == n - 1), rb(), rb(), rb(), $urandom, ctl_v(0,0,0,0,0,0,2'b00,1,m_cause), 0, 0);
    m_opcode = '0; m_retired = '0; m_cause = 2'b00;
    start_cycle();
  endtask

  task automatic fetch(input logic [31:0] ins, input int fd);
    for (int i = 0; i < fd; i++)
      push(0, 0, rb(), rb(), $urandom, ctl_v(1,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
    push(0, 1, rb(), rb(), ins, ctl_v(1,1,0,0,0,0,2'b00,0,2'b00), 0, 0);
    m_opcode = ins[6:0];
  endtask

  task automatic fetch_timeout();
    for (int i = 0; i <= int'(WAIT_MAX); i++)
      push(0, 0, rb(), rb(), $urandom, ctl_v(1,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
    m_cause = 2'b10;
    halt_reset(5);
  endtask

  task automatic body(input int dd, input logic br);
    logic [6:0] op;
    logic       is_ls, is_st, is_br, taken;
    logic [1:0] sel;
    op    = m_opcode;
    is_st = (op == OP_STORE);
    is_ls = (op == OP_LOAD) || is_st;
    is_br = (op == OP_BRANCH);
    push(0, rb(), rb(), rb(), $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
    if (!(op inside {legal_ops})) begin
      m_cause = 2'b01;
      halt_reset(6);
      return;
    end
    push(0, rb(), rb(), br, $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00),
         op inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR}, 1);
    taken = br && is_br;
    if (is_ls) begin
      if (dd > int'(WAIT_MAX)) begin
        for (int i = 0; i <= int'(WAIT_MAX); i++)
          push(0, rb(), 0, rb(), $urandom, ctl_v(0,0,1,is_st,0,0,2'b00,0,2'b00), 1, 1);
        m_cause = 2'b10;
        halt_reset(5);
        return;
      end
      for (int i = 0; i < dd; i++)
        push(0, rb(), 0, rb(), $urandom, ctl_v(0,0,1,is_st,0,0,2'b00,0,2'b00), 1, 1);
      push(0, rb(), 1, rb(), $urandom, ctl_v(0,0,1,is_st,0,0,2'b00,0,2'b00), 1, 1);
    end
    if (taken)              sel = 2'b01;
    else if (op == OP_JAL)  sel = 2'b10;
    else if (op == OP_JALR) sel = 2'b11;
    else                    sel = 2'b00;
    push(0, rb(), rb(), rb(), $urandom, ctl_v(0,0,0,0,!(is_st || is_br),1,sel,0,2'b00),
         0, (op == OP_R));
    m_retired = m_retired + 32'd1;
  endtask

  // scoreboard replay: inputs just after the rising edge, outputs on the falling edge
  task automatic play();
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      rst = c.r; i_ack = c.ia; d_ack = c.da; branch = c.br; instr = c.ins;
      @(negedge clk);
      check("ctl", 32'(ctl_now()), 32'(c.ctl));
      if (c.alu_care) check("alu_src", 32'(ALU_source), 32'(c.alu));
      check("opcode", 32'(opcode), 32'(c.opc));
      check("retired", retired, c.ret);
      @(posedge clk); #1;
      cyc_no++;
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ctl", 32'(ctl_now()), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_retired", retired, 32'h0);
    @(posedge clk); #1;

    start_cycle();
    fetch(32'h00208033, 0); body(0, rb());
    fetch(32'h0000A083, 0); body(3, 0);
    fetch(32'h00208063, 0); body(0, 1);
    fetch(32'h00208063, 1); body(0, 0);
    fetch(32'h0020A023, int'(WAIT_MAX)); body(int'(WAIT_MAX), 0);
    fetch(32'h008000EF, 2); body(0, 1);
    fetch(32'h000080E7, 0); body(0, 1);
    for (int n = 0; n < 40; n++) begin
      v = $urandom;
      v[6:0] = legal_ops[$urandom_range(0, 8)];
      fetch(v, $urandom_range(0, WAIT_MAX));
      body($urandom_range(0, WAIT_MAX), rb());
    end
    fetch(32'h0000007F, 0); body(0, 0);
    fetch(32'h00000033, 1); body(0, 0);
    fetch_timeout();
    fetch(32'h0000A083, 0); body(int'(WAIT_MAX) + 1, 0);

    // rst during MEM of a store; a late d_ack in the START cycle must be ignored
    fetch(32'h0020A023, 0);
    push(0, 0, 0, 0, $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
    push(0, 0, 0, 0, $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00), 1, 1);
    push(0, 0, 0, 0, $urandom, ctl_v(0,0,1,1,0,0,2'b00,0,2'b00), 1, 1);
    push(1, 0, 0, 0, $urandom, ctl_v(0,0,1,1,0,0,2'b00,0,2'b00), 1, 1);
    m_opcode = '0; m_retired = '0; m_cause = 2'b00;
    push(0, 0, 1, 0, $urandom, ctl_v(0,0,0,0,0,0,2'b00,0,2'b00), 0, 0);
    fetch(32'h00208033, 0); body(0, 0);

    play();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
